// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-to-execute operand fetch with bypass, load-use stall and ID/EX register
// Ports: Clk/Rst (async active-low); In* decoder handshake and fields;
//        Rf* register file read port; Ex*/Mem*/Wb* bypass sources;
//        Flush squash; Out* ID/EX register with OutValid/OutReady handshake.
module operand_fetch #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ADDR_W-1:0] InRs1Addr,
    input  logic [ADDR_W-1:0] InRs2Addr,
    input  logic              InRs1En,
    input  logic              InRs2En,
    input  logic [ADDR_W-1:0] InRdAddr,
    input  logic              InRdWe,
    input  logic              InIsLoad,
    input  logic [DATA_W-1:0] InPc,
    input  logic [DATA_W-1:0] InImm,
    output logic [ADDR_W-1:0] RfRs1Addr,
    output logic [ADDR_W-1:0] RfRs2Addr,
    output logic              RfRs1En,
    output logic              RfRs2En,
    input  logic [DATA_W-1:0] RfRs1Data,
    input  logic [DATA_W-1:0] RfRs2Data,
    input  logic [ADDR_W-1:0] ExRdAddr,
    input  logic              ExRdWe,
    input  logic              ExIsLoad,
    input  logic [DATA_W-1:0] ExData,
    input  logic [ADDR_W-1:0] MemRdAddr,
    input  logic              MemRdWe,
    input  logic [DATA_W-1:0] MemData,
    input  logic [ADDR_W-1:0] WbRdAddr,
    input  logic              WbRdWe,
    input  logic [DATA_W-1:0] WbData,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutRs1Data,
    output logic [DATA_W-1:0] OutRs2Data,
    output logic [ADDR_W-1:0] OutRdAddr,
    output logic              OutRdWe,
    output logic              OutIsLoad,
    output logic [DATA_W-1:0] OutPc,
    output logic [DATA_W-1:0] OutImm
);

    logic              out_valid_q,    out_valid_d;
    logic [DATA_W-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [DATA_W-1:0] out_rs2_data_q, out_rs2_data_d;
    logic [ADDR_W-1:0] out_rd_addr_q,  out_rd_addr_d;
    logic              out_rd_we_q,    out_rd_we_d;
    logic              out_is_load_q,  out_is_load_d;
    logic [DATA_W-1:0] out_pc_q,       out_pc_d;
    logic [DATA_W-1:0] out_imm_q,      out_imm_d;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              hazard;
    logic              free;
    logic              fire;

    // A load in EX has no data yet, so its match is excluded here; the
    // hazard logic stalls the consumer instead. The WB leg covers the
    // register file's synchronous write, which is not yet visible on the
    // asynchronous read port in the same cycle.
    function automatic logic [DATA_W-1:0] resolve(
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic [ADDR_W-1:0] ex_addr,
        input logic              ex_we,
        input logic              ex_load,
        input logic [DATA_W-1:0] ex_data,
        input logic [ADDR_W-1:0] mem_addr,
        input logic              mem_we,
        input logic [DATA_W-1:0] mem_data,
        input logic [ADDR_W-1:0] wb_addr,
        input logic              wb_we,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] val;
        if (!en || addr == '0)
            val = '0;
        else if (ex_we && !ex_load && ex_addr == addr)
            val = ex_data;
        else if (mem_we && mem_addr == addr)
            val = mem_data;
        else if (wb_we && wb_addr == addr)
            val = wb_data;
        else
            val = rf_data;
        return val;
    endfunction

    always_comb begin
        rs1_val = resolve(InRs1En, InRs1Addr, RfRs1Data, ExRdAddr, ExRdWe, ExIsLoad, ExData,
                          MemRdAddr, MemRdWe, MemData, WbRdAddr, WbRdWe, WbData);
        rs2_val = resolve(InRs2En, InRs2Addr, RfRs2Data, ExRdAddr, ExRdWe, ExIsLoad, ExData,
                          MemRdAddr, MemRdWe, MemData, WbRdAddr, WbRdWe, WbData);
    end

    always_comb begin
        hazard  = InValid && ExRdWe && ExIsLoad && (ExRdAddr != '0) &&
                  ((InRs1En && InRs1Addr == ExRdAddr) || (InRs2En && InRs2Addr == ExRdAddr));
        free    = !out_valid_q || OutReady;
        InReady = free && !hazard && !Flush;
        fire    = InValid && InReady;
    end

    assign RfRs1Addr = InRs1Addr;
    assign RfRs2Addr = InRs2Addr;
    assign RfRs1En   = InRs1En && InValid;
    assign RfRs2En   = InRs2En && InValid;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_we_d    = out_rd_we_q;
        out_is_load_d  = out_is_load_q;
        out_pc_d       = out_pc_q;
        out_imm_d      = out_imm_q;
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d    = 1'b1;
            out_rs1_data_d = rs1_val;
            out_rs2_data_d = rs2_val;
            out_rd_addr_d  = InRdAddr;
            out_rd_we_d    = InRdWe;
            out_is_load_d  = InIsLoad;
            out_pc_d       = InPc;
            out_imm_d      = InImm;
        end else if (free) begin
            // Slot drains with nothing acceptable behind it: issue a bubble.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_valid_q    <= 1'b0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_rd_addr_q  <= '0;
            out_rd_we_q    <= 1'b0;
            out_is_load_q  <= 1'b0;
            out_pc_q       <= '0;
            out_imm_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_we_q    <= out_rd_we_d;
            out_is_load_q  <= out_is_load_d;
            out_pc_q       <= out_pc_d;
            out_imm_q      <= out_imm_d;
        end
    end

    assign OutValid   = out_valid_q;
    assign OutRs1Data = out_rs1_data_q;
    assign OutRs2Data = out_rs2_data_q;
    assign OutRdAddr  = out_rd_addr_q;
    assign OutRdWe    = out_rd_we_q;
    assign OutIsLoad  = out_is_load_q;
    assign OutPc      = out_pc_q;
    assign OutImm     = out_imm_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [AW-1:0] InRs1Addr, InRs2Addr;
    logic          InRs1En, InRs2En;
    logic [AW-1:0] InRdAddr;
    logic          InRdWe, InIsLoad;
    logic [DW-1:0] InPc, InImm;
    logic [AW-1:0] RfRs1Addr, RfRs2Addr;
    logic          RfRs1En, RfRs2En;
    logic [DW-1:0] RfRs1Data, RfRs2Data;
    logic [AW-1:0] ExRdAddr;
    logic          ExRdWe, ExIsLoad;
    logic [DW-1:0] ExData;
    logic [AW-1:0] MemRdAddr;
    logic          MemRdWe;
    logic [DW-1:0] MemData;
    logic [AW-1:0] WbRdAddr;
    logic          WbRdWe;
    logic [DW-1:0] WbData;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutRs1Data, OutRs2Data;
    logic [AW-1:0] OutRdAddr;
    logic          OutRdWe, OutIsLoad;
    logic [DW-1:0] OutPc, OutImm;

    operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady),
        .InRs1Addr(InRs1Addr), .InRs2Addr(InRs2Addr),
        .InRs1En(InRs1En), .InRs2En(InRs2En),
        .InRdAddr(InRdAddr), .InRdWe(InRdWe), .InIsLoad(InIsLoad),
        .InPc(InPc), .InImm(InImm),
        .RfRs1Addr(RfRs1Addr), .RfRs2Addr(RfRs2Addr),
        .RfRs1En(RfRs1En), .RfRs2En(RfRs2En),
        .RfRs1Data(RfRs1Data), .RfRs2Data(RfRs2Data),
        .ExRdAddr(ExRdAddr), .ExRdWe(ExRdWe), .ExIsLoad(ExIsLoad), .ExData(ExData),
        .MemRdAddr(MemRdAddr), .MemRdWe(MemRdWe), .MemData(MemData),
        .WbRdAddr(WbRdAddr), .WbRdWe(WbRdWe), .WbData(WbData),
        .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutRs1Data(OutRs1Data), .OutRs2Data(OutRs2Data),
        .OutRdAddr(OutRdAddr), .OutRdWe(OutRdWe), .OutIsLoad(OutIsLoad),
        .OutPc(OutPc), .OutImm(OutImm)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        InValid = 0; InRs1Addr = 0; InRs2Addr = 0; InRs1En = 0; InRs2En = 0;
        InRdAddr = 0; InRdWe = 0; InIsLoad = 0; InPc = 0; InImm = 0;
        RfRs1Data = 0; RfRs2Data = 0;
        ExRdAddr = 0; ExRdWe = 0; ExIsLoad = 0; ExData = 0;
        MemRdAddr = 0; MemRdWe = 0; MemData = 0;
        WbRdAddr = 0; WbRdWe = 0; WbData = 0;
        Flush = 0; OutReady = 1;
    endtask

    initial begin
        Rst = 0;
        clear_inputs();
        #2;
        check_eq("rst_out_valid", OutValid, 0);
        check_eq("rst_out_rs1", OutRs1Data, 0);
        check_eq("rst_out_pc", OutPc, 0);
        #10 Rst = 1;
        tick();
        check_eq("idle_in_ready", InReady, 1);
        check_eq("idle_out_valid", OutValid, 0);

        // Forwarding priority on rs1
        InValid = 1; InRs1En = 1; InRs1Addr = 5; InRs2En = 1; InRs2Addr = 2;
        RfRs2Data = 64'h2;
        InRdAddr = 9; InRdWe = 1; InPc = 64'h100; InImm = 64'h8;
        ExRdAddr = 5; ExRdWe = 1; ExData = 64'h11;
        MemRdAddr = 5; MemRdWe = 1; MemData = 64'h22;
        WbRdAddr = 5; WbRdWe = 1; WbData = 64'h33;
        RfRs1Data = 64'h44;
        #1;
        check_eq("fwd_in_ready", InReady, 1);
        check_eq("fwd_rf_addr", RfRs1Addr, 5);
        check_eq("fwd_rf_en", RfRs1En, 1);
        tick();
        check_eq("fwd_valid", OutValid, 1);
        check_eq("fwd_ex", OutRs1Data, 64'h11);
        check_eq("fwd_rs2_rf", OutRs2Data, 64'h2);
        check_eq("fwd_pc", OutPc, 64'h100);
        check_eq("fwd_imm", OutImm, 64'h8);
        check_eq("fwd_rd_addr", OutRdAddr, 9);
        check_eq("fwd_rd_we", OutRdWe, 1);
        ExRdWe = 0;
        tick();
        check_eq("fwd_mem", OutRs1Data, 64'h22);
        MemRdWe = 0;
        tick();
        check_eq("fwd_wb", OutRs1Data, 64'h33);
        WbRdWe = 0;
        tick();
        check_eq("fwd_rf", OutRs1Data, 64'h44);

        // x0 and disabled source
        clear_inputs();
        InValid = 1; InRs2En = 1; InRs2Addr = 0; RfRs2Data = 64'h55;
        ExRdAddr = 0; ExRdWe = 1; ExData = 64'hDEAD;
        tick();
        check_eq("x0_rs2", OutRs2Data, 0);
        InRs2En = 0; InRs2Addr = 7; ExRdAddr = 7; RfRs2Data = 64'h77;
        #1;
        check_eq("dis_rf_en", RfRs2En, 0);
        check_eq("dis_rf_addr", RfRs2Addr, 7);
        tick();
        check_eq("dis_rs2", OutRs2Data, 0);
        clear_inputs();
        InValid = 1; InRs2En = 1; InRs2Addr = 6; WbRdAddr = 6; WbRdWe = 1;
        WbData = 64'h66; RfRs2Data = 64'h1;
        tick();
        check_eq("rs2_wb", OutRs2Data, 64'h66);
        InValid = 0;
        #1;
        check_eq("rf_en_gated", RfRs2En, 0);

        // Load-use: one bubble, then MEM bypass
        clear_inputs();
        ExRdAddr = 3; ExRdWe = 1; ExIsLoad = 1; ExData = 64'hBAD;
        InValid = 1; InRs1En = 1; InRs1Addr = 3; InPc = 64'h300;
        #1;
        check_eq("lu_in_ready", InReady, 0);
        tick();
        check_eq("lu_bubble", OutValid, 0);
        ExRdWe = 0; ExIsLoad = 0;
        MemRdAddr = 3; MemRdWe = 1; MemData = 64'h99;
        #1;
        check_eq("lu_in_ready2", InReady, 1);
        tick();
        check_eq("lu_valid", OutValid, 1);
        check_eq("lu_rs1", OutRs1Data, 64'h99);
        check_eq("lu_pc", OutPc, 64'h300);

        // Backpressure: held entry unaffected by bypass activity
        OutReady = 0; InPc = 64'h400;
        for (int i = 0; i < 3; i++) begin
            MemData = 64'hA0 + 64'(i);
            ExRdAddr = 3; ExRdWe = 1; ExData = 64'hE0 + 64'(i);
            WbRdAddr = 3; WbRdWe = 1; WbData = 64'hB0 + 64'(i);
            #1;
            check_eq("bp_in_ready", InReady, 0);
            tick();
            check_eq("bp_valid", OutValid, 1);
            check_eq("bp_rs1", OutRs1Data, 64'h99);
            check_eq("bp_pc", OutPc, 64'h300);
        end
        ExRdWe = 0; MemData = 64'hC0; OutReady = 1;
        #1;
        check_eq("bp_release_ready", InReady, 1);
        tick();
        check_eq("bp_next_pc", OutPc, 64'h400);
        check_eq("bp_next_rs1", OutRs1Data, 64'hC0);

        // Flush with a clean instruction
        clear_inputs();
        InValid = 1; InPc = 64'h500; Flush = 1;
        #1;
        check_eq("fl_in_ready", InReady, 0);
        tick();
        check_eq("fl_valid", OutValid, 0);
        Flush = 0;
        tick();
        check_eq("fl_refire_pc", OutPc, 64'h500);
        OutReady = 0; Flush = 1;
        tick();
        check_eq("fl_while_held", OutValid, 0);
        Flush = 0; OutReady = 1;

        // Flush during a load-use stall
        ExRdAddr = 3; ExRdWe = 1; ExIsLoad = 1;
        InValid = 1; InRs1En = 1; InRs1Addr = 3; InPc = 64'h600;
        tick();
        check_eq("fls_bubble", OutValid, 0);
        Flush = 1;
        #1;
        check_eq("fls_in_ready", InReady, 0);
        tick();
        check_eq("fls_valid", OutValid, 0);
        Flush = 0; ExRdWe = 0; ExIsLoad = 0;
        MemRdAddr = 3; MemRdWe = 1; MemData = 64'h77;
        tick();
        check_eq("fls_after_pc", OutPc, 64'h600);
        check_eq("fls_after_rs1", OutRs1Data, 64'h77);

        // Asynchronous reset while holding
        InValid = 0; OutReady = 0;
        tick();
        check_eq("rsth_held", OutValid, 1);
        #2 Rst = 0;
        #1;
        check_eq("rsth_valid", OutValid, 0);
        check_eq("rsth_rs1", OutRs1Data, 0);
        check_eq("rsth_pc", OutPc, 0);
        Rst = 1; OutReady = 1;
        #1;
        check_eq("rsth_in_ready", InReady, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute stage wrapped around the register file: drives the register file read ports and merges the read data with bypass values from EX, MEM and WB.
- Detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register behind a valid/ready handshake.
- Upstream is the decoder, downstream is the ALU/execute stage.

Parameters:
- DATA_W, 64, width of register data, PC and immediate.
- ADDR_W, 5, register address width (32 architectural registers; x0 hard-wired zero).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active low.
- InValid  in  1  decoder presents an instruction.
- InReady  out  1  stage accepts the instruction this cycle.
- InRs1Addr/InRs2Addr  in  ADDR_W each  source register addresses.
- InRs1En/InRs2En  in  1 each  source operand is used.
- InRdAddr  in  ADDR_W  destination register address.
- InRdWe  in  1  instruction writes rd.
- InIsLoad  in  1  instruction is a load.
- InPc/InImm  in  DATA_W each  PC and decoded immediate.
- RfRs1Addr/RfRs2Addr  out  ADDR_W each  register file read addresses; combinational copy of InRs*Addr.
- RfRs1En/RfRs2En  out  1 each  register file read enables; InRs*En gated by InValid.
- RfRs1Data/RfRs2Data  in  DATA_W each  asynchronous register file read data.
- ExRdAddr, ExRdWe, ExIsLoad, ExData  in  ADDR_W/1/1/DATA_W  instruction currently in EX.
- MemRdAddr, MemRdWe, MemData  in  ADDR_W/1/DATA_W  instruction in MEM.
- WbRdAddr, WbRdWe, WbData  in  ADDR_W/1/DATA_W  writeback; same signals drive the register file write port.
- Flush  in  1  branch/exception squash.
- OutValid  out  1  ID/EX register holds a valid instruction.
- OutReady  in  1  execute consumes OutValid this cycle.
- OutRs1Data/OutRs2Data  out  DATA_W each  resolved operands.
- OutRdAddr, OutRdWe, OutIsLoad, OutPc, OutImm  out  registered copies of the corresponding In* fields.

Behaviour:
- Reset (Rst=0, async): OutValid=0 and every Out* register=0, regardless of Clk. The first capture occurs on the first rising edge after Rst deasserts.
- Operand resolve (combinational), per source s in {rs1, rs2}:
  - If InRsSEn=0 or addr=0, the operand is 0.
  - Otherwise the priority is EX match > MEM match > WB match > RfRsSData.
  - A match requires the stage's RdWe=1, RdAddr==addr and addr!=0.
  - The EX match uses ExData. It is never used when ExIsLoad=1; that case is a hazard.
  - The WB bypass is mandatory because the register file write is synchronous.
- Hazard: hazard = InValid and ExRdWe and ExIsLoad and ExRdAddr!=0 and ((InRs1En and InRs1Addr==ExRdAddr) or (InRs2En and InRs2Addr==ExRdAddr)).
- Slot free: free = !OutValid or OutReady.
- Handshake: InReady = free and !hazard and !Flush. Fire = InValid and InReady.
- Register update on the rising edge, first applicable rule wins:
  1. Flush=1: OutValid<=0; the input is not accepted; the data registers may hold.
  2. Fire: OutValid<=1; capture resolved operands and all In* fields.
  3. free and (hazard or !InValid): OutValid<=0 (bubble); the data registers may hold.
  4. Otherwise (OutValid=1, OutReady=0): every Out* register holds unchanged.
- Latency: one cycle from accept to OutValid.
- Throughput: one instruction per cycle with no hazards and OutReady=1.
- A load-use pair costs exactly one bubble. The next cycle the load is in MEM and the MEM bypass supplies the value.
- OutValid must not drop while OutReady=0, except on Flush.
- A held entry keeps the operands captured at fire. Later EX/MEM/WB activity must not modify it.
- Flush asserted in the same cycle as a hazard or a fire: Flush wins.
- Rst asserted mid-stall or mid-hold: all outputs go to 0 immediately.

Test Plan:
- Reset: drive Rst=0 mid-cycle with OutValid=1 -> OutValid=0 and OutRs1Data=0 with no clock edge. After release, InReady=1 once OutReady=1.
- Forward priority: rs1=x5; ExRdAddr=5/ExData=0x11, MemRdAddr=5/MemData=0x22, WbRdAddr=5/WbData=0x33, RfRs1Data=0x44 -> OutRs1Data=0x11. Drop ExRdWe -> 0x22. Drop MemRdWe -> 0x33. Drop WbRdWe -> 0x44.
- x0: rs2=x0, ExRdAddr=0, ExRdWe=1, ExData=0xDEAD -> OutRs2Data=0. Repeat with InRs2En=0 and rs2=x7 -> OutRs2Data=0.
- Load-use: ld x3 in EX (ExIsLoad=1, ExRdAddr=3); add reads x3 -> InReady=0 for one cycle and a bubble is issued (OutValid=0). Next cycle MemRdAddr=3, MemData=0x99 -> add captured with OutRs1Data=0x99.
- Backpressure: OutValid=1, OutReady=0 for 3 cycles while EX/MEM/WB data change -> all Out* stable and InReady=0. OutReady=1 -> next instruction captured on that edge.
- Flush: Flush=1 with InValid=1 and no hazard -> InReady=0 and OutValid=0 next cycle. Flush=1 during a load-use stall -> OutValid=0 and nothing accepted.
